layer_par_mvm: RTL and testbench



---
 rtl/layer_pkg.sv | 25 ++
 rtl/layer_par_mvm_mac_lane.sv | 63 ++++++
 rtl/layer_par_mvm.sv | 155 +++++++++++++++
 tb/tb_layer_par_mvm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared types and helpers for the parallel matrix-vector layer engine.
package layer_pkg;

  typedef enum logic [2:0] {LOAD_W, LOAD_B, LOAD_X, MAC, DRAIN, OUT} state_t;

  // Accumulator wide enough for N full products plus the bias, so it can never overflow.
  function automatic int acc_width(input int t, input int n);
    return 2 * t + $clog2(n);
  endfunction

  // Clamp a sign-extended accumulator to the signed t-bit range (t <= 32).
  function automatic logic signed [31:0] sat(input logic signed [63:0] a, input int t);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    if (a > hi)
      return 32'(hi);
    else if (a < lo)
      return 32'(lo);
    else
      return 32'(a);
  endfunction

endpackage

// File: rtl/layer_par_mvm_mac_lane.sv
// One MAC lane: private W/b banks, registered read, registered multiplier, accumulator.
module mac_lane
  import layer_pkg::*;
#(
  parameter int N  = 8,
  parameter int T  = 12,
  parameter int G  = 4,
  parameter int WA = 5,
  parameter int GW = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              w_we,
  input  logic                              b_we,
  input  logic [WA-1:0]                     w_addr,
  input  logic [GW-1:0]                     b_addr,
  input  logic signed [T-1:0]               wdata,
  input  logic signed [T-1:0]               x_q,
  input  logic                              rd_en,
  input  logic                              first,
  output logic signed [acc_width(T,N)-1:0]  acc
);

  localparam int AW = acc_width(T, N);
  localparam int PW = 2 * T;

  logic signed [T-1:0]  w_mem [G*N];
  logic signed [T-1:0]  b_mem [G];
  logic signed [T-1:0]  w_q;
  logic signed [T-1:0]  b_q;
  logic signed [PW-1:0] prod;
  logic                 v1, f1, v2, f2;

  always_ff @(posedge clk) begin
    if (w_we)
      w_mem[w_addr] <= wdata;
    if (b_we)
      b_mem[b_addr] <= wdata;
    w_q <= w_mem[w_addr];
    b_q <= b_mem[b_addr];
  end

  // The first product of a row reloads the accumulator from the bias instead of adding.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      f1   <= 1'b0;
      v2   <= 1'b0;
      f2   <= 1'b0;
      prod <= '0;
      acc  <= '0;
    end else begin
      v1   <= rd_en;
      f1   <= first;
      v2   <= v1;
      f2   <= f1;
      prod <= PW'(w_q) * PW'(x_q);
      if (v2)
        acc <= (f2 ? AW'(b_q) : acc) + AW'(prod);
    end
  end

endmodule

// File: rtl/layer_par_mvm.sv
// Fully-connected layer y = act(W*x + b) with P parallel MAC lanes and streamed W/b/x.
// Define RELU_EN for ReLU activation; otherwise the activation is identity.
module layer_par_mvm
  import layer_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 8,
  parameter int T = 12,
  parameter int P = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out
);

  localparam int G  = M / P;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int WA = (G * N > 1) ? $clog2(G * N) : 1;
  localparam int AW = acc_width(T, N);
  localparam logic [WA-1:0] N_W = WA'(N);

  state_t               state, state_nx;
  logic [CW-1:0]        col_cnt;
  logic [LW-1:0]        lane_idx;
  logic [GW-1:0]        grp_idx;
  logic                 drain_cnt;
  logic                 hs, col_last, lane_last, grp_last;
  logic [WA-1:0]        w_addr;
  logic signed [T-1:0]  x_mem [N];
  logic signed [T-1:0]  x_q;
  logic signed [AW-1:0] acc_arr [P];
  logic [LW-1:0]        sel;
  logic signed [T-1:0]  conv;

  assign s_ready   = !reset && (state == LOAD_W || state == LOAD_B || state == LOAD_X);
  assign hs        = s_valid && s_ready;
  assign col_last  = (col_cnt == CW'(N - 1));
  assign lane_last = (lane_idx == LW'(P - 1));
  assign grp_last  = (grp_idx == GW'(G - 1));
  assign w_addr    = WA'(grp_idx) * N_W + WA'(col_cnt);

  always_ff @(posedge clk) begin
    if (reset)
      state <= LOAD_W;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD_W:  if (hs && col_last && lane_last && grp_last) state_nx = LOAD_B;
      LOAD_B:  if (hs && lane_last && grp_last) state_nx = LOAD_X;
      LOAD_X:  if (hs && col_last) state_nx = MAC;
      MAC:     if (col_last) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = OUT;
      OUT:     if (m_valid && m_ready && lane_last) state_nx = grp_last ? LOAD_X : MAC;
      default: state_nx = LOAD_W;
    endcase
  end

  // lane_idx doubles as the W/b lane selector while loading and the output word index in OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt   <= '0;
      lane_idx  <= '0;
      grp_idx   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        LOAD_W: if (hs) begin
          col_cnt <= col_last ? '0 : col_cnt + CW'(1);
          if (col_last) begin
            lane_idx <= lane_last ? '0 : lane_idx + LW'(1);
            if (lane_last)
              grp_idx <= grp_last ? '0 : grp_idx + GW'(1);
          end
        end
        LOAD_B: if (hs) begin
          lane_idx <= lane_last ? '0 : lane_idx + LW'(1);
          if (lane_last)
            grp_idx <= grp_last ? '0 : grp_idx + GW'(1);
        end
        LOAD_X: if (hs) col_cnt <= col_last ? '0 : col_cnt + CW'(1);
        MAC:    col_cnt <= col_last ? '0 : col_cnt + CW'(1);
        DRAIN:  drain_cnt <= ~drain_cnt;
        OUT: if (m_valid && m_ready) begin
          lane_idx <= lane_last ? '0 : lane_idx + LW'(1);
          if (lane_last)
            grp_idx <= grp_last ? '0 : grp_idx + GW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD_X && hs)
      x_mem[col_cnt] <= data_in;
    x_q <= x_mem[col_cnt];
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    mac_lane #(.N(N), .T(T), .G(G), .WA(WA), .GW(GW)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .w_we   (state == LOAD_W && hs && lane_idx == LW'(p)),
      .b_we   (state == LOAD_B && hs && lane_idx == LW'(p)),
      .w_addr (w_addr),
      .b_addr (grp_idx),
      .wdata  (data_in),
      .x_q    (x_q),
      .rd_en  (state == MAC),
      .first  (col_cnt == '0),
      .acc    (acc_arr[p])
    );
  end

  // Picks the word to load next: lane 0 on OUT entry, then the following lane per handshake.
  always_comb begin
    sel = '0;
    if (m_valid && !lane_last)
      sel = lane_idx + LW'(1);
    conv = T'(sat(64'(acc_arr[sel]), T));
`ifdef RELU_EN
    if (conv[T-1])
      conv = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b0;
      data_out <= '0;
    end else if (state == OUT) begin
      if (!m_valid) begin
        m_valid  <= 1'b1;
        data_out <= conv;
      end else if (m_ready) begin
        if (lane_last)
          m_valid <= 1'b0;
        else
          data_out <= conv;
      end
    end
  end

endmodule

// File: tb/tb_layer_par_mvm.sv
// Directed bench for layer_par_mvm with M=4, N=4, T=12, P=2; honours RELU_EN.
`timescale 1ns/1ps
module tb_layer_par_mvm;

  localparam int M = 4;
  localparam int N = 4;
  localparam int T = 12;
  localparam int P = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] data_in;
  logic                m_valid;
  logic                m_ready;
  logic signed [T-1:0] data_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic signed [T-1:0] wv [M*N];
  logic signed [T-1:0] bv [M];
  logic signed [T-1:0] xv [N];
  logic signed [T-1:0] ev [M];

  layer_par_mvm #(.M(M), .N(N), .T(T), .P(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [T-1:0] act(input logic signed [T-1:0] v);
`ifdef RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkValue(input string tag, input logic signed [T-1:0] obs, input logic signed [T-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic signed [T-1:0] w);
    int n = 0;
    data_in = w;
    s_valid = 1'b1;
    #1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $error("[TB] FAIL s_ready_timeout observed 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic checkOutput(input logic signed [T-1:0] exp, input string tag);
    int n = 0;
    while (m_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkBit({tag, "_valid"}, m_valid, 1'b1);
    checkValue(tag, data_out, exp);
    checkBit({tag, "_sready"}, s_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic loadParams();
    for (int i = 0; i < M * N; i++) applyStimulus(wv[i]);
    for (int i = 0; i < M; i++) applyStimulus(bv[i]);
  endtask

  task automatic sendVector();
    for (int i = 0; i < N; i++) applyStimulus(xv[i]);
  endtask

  task automatic readVector(input string tag);
    for (int r = 0; r < M; r++) checkOutput(act(ev[r]), $sformatf("%s_y%0d", tag, r));
    checkBit({tag, "_done_mvalid"}, m_valid, 1'b0);
    checkBit({tag, "_done_sready"}, s_ready, 1'b1);
  endtask

  task automatic setIdentity(input logic signed [T-1:0] b);
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) wv[r*N+c] = (r == c) ? 12'sd1 : 12'sd0;
      bv[r] = b;
    end
  endtask

  task automatic doReset();
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    data_in = '0;
    @(negedge clk);
    @(negedge clk);
    checkBit("rst_sready", s_ready, 1'b0);
    checkBit("rst_mvalid", m_valid, 1'b0);
    checkValue("rst_dout", data_out, 12'sd0);

    // A word offered during reset must be ignored.
    s_valid = 1'b1;
    data_in = 12'sd77;
    @(negedge clk);
    checkBit("rst_sready_with_valid", s_ready, 1'b0);
    s_valid = 1'b0;
    reset   = 1'b0;
    #1;
    checkBit("sready_after_rst", s_ready, 1'b1);

    $display("[TB] identity W, b=0, latency");
    setIdentity(12'sd0);
    loadParams();
    xv = '{12'sd1, 12'sd2, 12'sd3, 12'sd4};
    ev = '{12'sd1, 12'sd2, 12'sd3, 12'sd4};
    sendVector();
    checkBit("mac_sready", s_ready, 1'b0);
    repeat (6) @(negedge clk);
    checkBit("lat_e0p6_mvalid", m_valid, 1'b0);
    @(negedge clk);
    checkBit("lat_e0p7_mvalid", m_valid, 1'b1);
    readVector("ident");

    $display("[TB] output backpressure");
    xv = '{12'sd5, 12'sd6, 12'sd7, 12'sd8};
    sendVector();
    checkOutput(12'sd5, "stall_y0");
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkValue($sformatf("stall_hold%0d", i), data_out, 12'sd6);
      checkBit($sformatf("stall_valid%0d", i), m_valid, 1'b1);
      @(negedge clk);
    end
    m_ready = 1'b1;
    checkOutput(12'sd6, "stall_y1");
    checkOutput(12'sd7, "stall_y2");
    checkOutput(12'sd8, "stall_y3");
    checkBit("stall_done_mvalid", m_valid, 1'b0);

    $display("[TB] negative bias");
    doReset();
    setIdentity(-12'sd5);
    loadParams();
    xv = '{12'sd1, 12'sd2, 12'sd3, 12'sd4};
    ev = '{-12'sd4, -12'sd3, -12'sd2, -12'sd1};
    sendVector();
    readVector("negb");

    $display("[TB] saturation");
    doReset();
    for (int i = 0; i < M * N; i++) wv[i] = 12'sd2047;
    bv = '{12'sd0, 12'sd0, 12'sd0, 12'sd0};
    loadParams();
    xv = '{12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047};
    ev = '{12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047};
    sendVector();
    readVector("satpos");
    doReset();
    for (int i = 0; i < M * N; i++) wv[i] = -12'sd2048;
    loadParams();
    ev = '{-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048};
    sendVector();
    readVector("satneg");

    $display("[TB] general W, three back-to-back vectors");
    doReset();
    wv = '{12'sd1,  12'sd2,  12'sd3, 12'sd4,
           -12'sd1, 12'sd0,  12'sd1, 12'sd0,
           12'sd2,  12'sd2,  12'sd2, 12'sd2,
           12'sd0,  -12'sd3, 12'sd0, 12'sd5};
    bv = '{12'sd10, -12'sd20, 12'sd0, 12'sd7};
    loadParams();
    xv = '{12'sd3, -12'sd1, 12'sd2, 12'sd1};
    ev = '{12'sd21, -12'sd21, 12'sd10, 12'sd15};
    sendVector();
    readVector("vecA");
    xv = '{12'sd1, 12'sd1, 12'sd1, 12'sd1};
    ev = '{12'sd20, -12'sd20, 12'sd8, 12'sd9};
    sendVector();
    readVector("vecB");
    xv = '{12'sd0, 12'sd0, 12'sd0, -12'sd2};
    ev = '{12'sd2, -12'sd20, -12'sd4, -12'sd3};
    sendVector();
    readVector("vecC");

    $display("[TB] reset during OUT");
    xv = '{12'sd3, -12'sd1, 12'sd2, 12'sd1};
    sendVector();
    checkOutput(act(12'sd21), "midout_y0");
    reset = 1'b1;
    @(negedge clk);
    checkBit("midout_rst_mvalid", m_valid, 1'b0);
    checkValue("midout_rst_dout", data_out, 12'sd0);
    checkBit("midout_rst_sready", s_ready, 1'b0);
    reset = 1'b0;
    #1;
    checkBit("midout_sready_after", s_ready, 1'b1);
    setIdentity(12'sd0);
    loadParams();
    xv = '{12'sd9, -12'sd7, 12'sd100, -12'sd1};
    ev = '{12'sd9, -12'sd7, 12'sd100, -12'sd1};
    sendVector();
    readVector("reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
